apb4_crc_feeder: RTL and testbench
==================================

# apb4_crc_feeder

Upstream stream-to-APB4 bridge that drives the APB4 CRC peripheral as bus master. Accepts a byte stream with valid/ready and frame-end marker, initialises the CRC unit at frame start, packs bytes into 32-bit data-register writes, then reads back the result register and presents the CRC with a one-cycle valid pulse. Replaces the software/test master when frames arrive from a hardware datapath.

## Interface
- ADDR_W, 12: APB address width
- CTRL_ADDR, 'h000: CRC control register address
- DATA_ADDR, 'h004: CRC data register address
- RES_ADDR, 'h008: CRC result register address
- CTRL_INIT, 32'h1: value written to CTRL_ADDR at frame start (enable + reload seed)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous and active-high
- s_valid_i  in  1  input byte valid
- s_ready_o  out  1  input byte accepted when valid & ready
- s_data_i  in  8  input byte
- s_last_i  in  1  marks final byte of frame
- paddr_o  out  ADDR_W  APB address
- pprot_o  out  3  constant 3'b000
- psel_o / penable_o / pwrite_o  out  1 each  APB control
- pwdata_o  out  32  write data
- pstrb_o  out  4  byte strobes (write only; 0 on reads)
- prdata_i  in  32  read data
- pready_i / pslverr_i  in  1 each  APB response
- crc_valid_o  out  1  one-cycle result pulse
- crc_o  out  32  result, held until next pulse
- err_o  out  1  qualified by crc_valid_o; frame saw pslverr

## Operation
- FSM states: IDLE, SETUP, ACCESS, COLLECT, DRAIN, DONE; op register ∈ {INIT, DATA, READ}.
- IDLE: s_ready_o=0. On s_valid_i=1 → op=INIT, SETUP (byte not consumed yet).
- SETUP: psel=1, penable=0, address/data/pwrite driven from op. Next cycle → ACCESS.
- ACCESS: psel=1, penable=1; hold all signals until pready_i=1. On completion: pslverr_i=1 sets error flag → DRAIN if frame's last byte not yet accepted, else DONE. Otherwise INIT→COLLECT; DATA→COLLECT, or op=READ→SETUP if word held last byte; READ→capture prdata_i into crc_o→DONE.
- COLLECT: s_ready_o=1. Accepted byte k goes to pwdata[8k+7:8k] (little-endian), k=0..3. Fourth byte or s_last_i → op=DATA, pstrb=(1<<n)-1 with n bytes held, → SETUP. Data bytes of words not full are zero.
- DRAIN: s_ready_o=1, bytes discarded until s_last_i accepted → DONE. No further APB traffic.
- DONE: crc_valid_o=1 one cycle, err_o=error flag; crc_o keeps last read value (unchanged if READ not reached). → IDLE; error flag and byte count clear.
- Frame of one byte: INIT, one DATA write pstrb=4'b0001, READ.

## Timing
- Reset values: s_ready_o=0, psel/penable/pwrite=0, paddr=0, pwdata=0, pstrb=0, crc_valid_o=0, crc_o=0, err_o=0; FSM=IDLE, counters 0.
- Reset mid-transfer: psel/penable drop at the reset edge; partial word and frame discarded; no result pulse.
- Every APB transfer ≥2 cycles; zero-wait-state slave: INIT 2 cycles, each DATA word ≥4 bytes-in + 2, READ 2.
- s_ready_o is registered-state based only (no combinational path from s_valid_i).
- Minimum latency s_last_i accept → crc_valid_o: 5 cycles with pready tied high (SETUP, ACCESS for DATA, SETUP, ACCESS for READ, DONE).
- pslverr_i sampled only when psel&penable&pready.

## Configuration
- APB4_CRC_FEEDER_PACK_EN defined: 4-byte packing as above.
- Undefined: each byte is its own DATA write, pwdata={24'b0,byte}, pstrb=4'b0001; COLLECT leaves after every accepted byte. FSM and register map otherwise identical.

## Structure
- Package crc_feeder_pkg: state enum, op enum, default address constants, CTRL_INIT default.
- One sub-module crc_byte_packer: byte lane counter, word/strobe assembly, last-flag capture; FSM stays in top.

## Test plan
- Frame 0x31..0x39 (9 bytes), pready=1: writes CTRL 0x1; DATA 0x34333231/f, 0x38373635/f, 0x00000039/1; READ; slave returns 0xCBF43926 → crc_valid_o pulse, crc_o=0xCBF43926, err_o=0.
- Same frame with pready low 3 cycles per access: signals stable during waits, identical write sequence, latency +3 per transfer.
- pslverr on second DATA write of 9-byte frame: remaining bytes drained, no READ, crc_valid_o pulse with err_o=1, crc_o unchanged.
- Single byte 0xA5 with s_last_i: DATA pwdata=0x000000A5, pstrb=4'b0001.
- rst_i during ACCESS of first DATA: psel=0 next cycle, no pulse; next frame starts with INIT.
- Macro undefined, 3-byte frame: three DATA writes, pstrb=4'b0001 each.

Source files
------------

// File: rtl/crc_feeder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | crc_feeder_pkg: shared states, opcodes and register-map defaults for        |
// | the stream-to-APB4 CRC feeder.                                              |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package crc_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    COLLECT = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    DATA = 2'd1,
    READ = 2'd2
  } op_t;

  localparam int          DEF_ADDR_W    = 12;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] DEF_DATA_ADDR = 32'h0000_0004;
  localparam logic [31:0] DEF_RES_ADDR  = 32'h0000_0008;
  localparam logic [31:0] DEF_CTRL_INIT = 32'h0000_0001;

  // Strobe for a word whose highest occupied lane is 'lane'.
  function automatic logic [3:0] lane_strb(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_strb = 4'b0001;
      2'd1:    lane_strb = 4'b0011;
      2'd2:    lane_strb = 4'b0111;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_byte_packer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | crc_byte_packer: gathers accepted bytes into a little-endian 32-bit word    |
// | with strobes and remembers whether the frame's last byte was taken.         |
// | Packing of up to 4 bytes per word only with APB4_CRC_FEEDER_PACK_EN.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module crc_byte_packer
  import crc_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic [3:0]  strb,
  output logic        word_end,
  output logic        last_held
);

  logic [1:0]  lane;
  logic [31:0] acc;

  // word/strb describe the word as it will be once the current byte lands.
  always_comb begin
    word = acc;
    word[{lane, 3'b000} +: 8] = data;
    strb = lane_strb(lane);
`ifdef APB4_CRC_FEEDER_PACK_EN
    word_end = (lane == 2'd3) || last;
`else
    word_end = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane      <= 2'd0;
      acc       <= 32'h0;
      last_held <= 1'b0;
    end else if (accept) begin
      if (last) last_held <= 1'b1;
      if (word_end) begin
        lane <= 2'd0;
        acc  <= 32'h0;
      end else begin
        lane <= lane + 2'd1;
        acc  <= word;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb4_crc_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb4_crc_feeder: byte stream in, APB4 master out; seeds the CRC unit,       |
// | writes frame data, reads the result. APB4_CRC_FEEDER_PACK_EN packs words.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module apb4_crc_feeder
  import crc_feeder_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEF_CTRL_ADDR),
  parameter logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(DEF_DATA_ADDR),
  parameter logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(DEF_RES_ADDR),
  parameter logic [31:0]       CTRL_INIT = DEF_CTRL_INIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [7:0]        s_data_i,
  input  logic              s_last_i,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [2:0]        pprot_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       pwdata_o,
  output logic [3:0]        pstrb_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              crc_valid_o,
  output logic [31:0]       crc_o,
  output logic              err_o
);

  state_t      state;
  op_t         op;
  logic        err_flag;
  logic        accept;
  logic [31:0] pk_word;
  logic [3:0]  pk_strb;
  logic        pk_end;
  logic        last_held;

  assign pprot_o = 3'b000;
  assign accept  = s_valid_i && s_ready_o && (state == COLLECT);

  crc_byte_packer u_packer (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (state == DONE),
    .accept    (accept),
    .data      (s_data_i),
    .last      (s_last_i),
    .word      (pk_word),
    .strb      (pk_strb),
    .word_end  (pk_end),
    .last_held (last_held)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      op          <= INIT;
      err_flag    <= 1'b0;
      s_ready_o   <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= 32'h0;
      pstrb_o     <= 4'h0;
      crc_valid_o <= 1'b0;
      crc_o       <= 32'h0;
      err_o       <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid_i) begin
            op       <= INIT;
            state    <= SETUP;
            psel_o   <= 1'b1;
            pwrite_o <= 1'b1;
            paddr_o  <= CTRL_ADDR;
            pwdata_o <= CTRL_INIT;
            pstrb_o  <= 4'hF;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            if (pslverr_i) begin
              err_flag <= 1'b1;
              // Remaining input of the frame must still be consumed.
              if (last_held) begin
                state       <= DONE;
                crc_valid_o <= 1'b1;
                err_o       <= 1'b1;
              end else begin
                state     <= DRAIN;
                s_ready_o <= 1'b1;
              end
            end else begin
              case (op)
                INIT: begin
                  state     <= COLLECT;
                  s_ready_o <= 1'b1;
                end
                DATA: begin
                  if (last_held) begin
                    op       <= READ;
                    state    <= SETUP;
                    psel_o   <= 1'b1;
                    pwrite_o <= 1'b0;
                    paddr_o  <= RES_ADDR;
                    pstrb_o  <= 4'h0;
                  end else begin
                    state     <= COLLECT;
                    s_ready_o <= 1'b1;
                  end
                end
                READ: begin
                  crc_o       <= prdata_i;
                  state       <= DONE;
                  crc_valid_o <= 1'b1;
                  err_o       <= err_flag;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
        COLLECT: begin
          if (s_valid_i && pk_end) begin
            s_ready_o <= 1'b0;
            op        <= DATA;
            state     <= SETUP;
            psel_o    <= 1'b1;
            pwrite_o  <= 1'b1;
            paddr_o   <= DATA_ADDR;
            pwdata_o  <= pk_word;
            pstrb_o   <= pk_strb;
          end
        end
        DRAIN: begin
          if (s_valid_i && s_last_i) begin
            s_ready_o   <= 1'b0;
            state       <= DONE;
            crc_valid_o <= 1'b1;
            err_o       <= err_flag;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb4_crc_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_apb4_crc_feeder: scoreboard bench; frame stimulus queues expected APB    |
// | transfers and results, a monitor pops and compares them.                    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_apb4_crc_feeder;

  localparam int ADDR_W = 12;
`ifdef APB4_CRC_FEEDER_PACK_EN
  localparam bit PACK_MODE = 1'b1;
`else
  localparam bit PACK_MODE = 1'b0;
`endif

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        strb;
  } apb_t;

  typedef struct {
    logic [31:0] crc;
    logic        err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h0;
  logic              s_last = 1'b0;
  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel, penable, pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata = 32'h0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic              crc_valid;
  logic [31:0]       crc;
  logic              err;

  apb4_crc_feeder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .s_last_i    (s_last),
    .paddr_o     (paddr),
    .pprot_o     (pprot),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr),
    .crc_valid_o (crc_valid),
    .crc_o       (crc),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  apb_t       exp_apb[$];
  res_t       exp_res[$];
  logic [7:0] frame[$];

  int          waits = 0;
  int          err_at = -1;
  int          xfer_idx = 0;
  logic [31:0] rdata_val = 32'h0;
  int          acc_cyc = 0;
  int          pulse_cyc = -1;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // APB slave: 'waits' low-pready cycles in ACCESS, error on transfer err_at.
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (psel && penable && !rst) begin
        if (wcnt >= waits) begin
          pready  = 1'b1;
          prdata  = rdata_val;
          pslverr = (xfer_idx == err_at);
          xfer_idx++;
        end else begin
          pready = 1'b0;
          wcnt++;
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    apb_t snap;
    apb_t e;
    res_t r;
    snap = '{1'b0, '0, 32'h0, 4'h0};
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (psel && !penable) snap = '{pwrite, paddr, pwdata, pstrb};
        if (psel && penable) begin
          chk("apb_stable", {pwrite, paddr, pwdata, pstrb} == {snap.wr, snap.addr, snap.wdata, snap.strb},
              {pwrite, paddr, pwdata, pstrb}, {snap.wr, snap.addr, snap.wdata, snap.strb});
          if (pready) begin
            if (exp_apb.size() == 0) begin
              chk("apb_unexpected", 1'b0, {pwrite, paddr, pstrb}, 0);
            end else begin
              e = exp_apb.pop_front();
              chk("apb_xfer",
                  pwrite == e.wr && paddr == e.addr && pstrb == e.strb && (!e.wr || pwdata == e.wdata),
                  {pwrite, paddr, pstrb, pwdata}, {e.wr, e.addr, e.strb, e.wdata});
            end
          end
        end
        if (crc_valid) begin
          pulse_cyc = cyc;
          if (exp_res.size() == 0) begin
            chk("pulse_unexpected", 1'b0, {err, crc}, 0);
          end else begin
            r = exp_res.pop_front();
            chk("result", crc == r.crc && err == r.err, {err, crc}, {r.err, r.crc});
          end
        end
      end
    end
  end

  // Expected transfer list for 'frame', truncated after transfer stop_at.
  task automatic expect_frame(input int stop_at);
    apb_t        lst[$];
    logic [31:0] w;
    int          lane;
    w    = 32'h0;
    lane = 0;
    lst.push_back('{1'b1, 12'h000, 32'h1, 4'hF});
    foreach (frame[i]) begin
      w[8*lane +: 8] = frame[i];
      if (!PACK_MODE || lane == 3 || i == frame.size() - 1) begin
        lst.push_back('{1'b1, 12'h004, w, 4'((1 << (lane + 1)) - 1)});
        w    = 32'h0;
        lane = 0;
      end else begin
        lane++;
      end
    end
    lst.push_back('{1'b0, 12'h008, 32'h0, 4'h0});
    for (int i = 0; i < lst.size(); i++)
      if (stop_at < 0 || i <= stop_at) exp_apb.push_back(lst[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("byte_accept_timeout", 1'b0, 64'(n), 200);
    acc_cyc = cyc + 1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_apb.size() != 0 || exp_res.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", exp_apb.size() == 0 && exp_res.size() == 0,
        64'(exp_apb.size() + exp_res.size()), 0);
  endtask

  task automatic run_frame(input int w, input logic [31:0] rd, input int stop_at,
                           input logic [31:0] exp_crc, input logic exp_err, input int exp_lat);
    waits     = w;
    rdata_val = rd;
    err_at    = stop_at;
    xfer_idx  = 0;
    pulse_cyc = -1;
    expect_frame(stop_at);
    exp_res.push_back('{exp_crc, exp_err});
    foreach (frame[i]) send_byte(frame[i], i == frame.size() - 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_empty();
    if (exp_lat >= 0) chk("latency", (pulse_cyc - acc_cyc) == exp_lat, 64'(pulse_cyc - acc_cyc), 64'(exp_lat));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready == 1'b0, 64'(s_ready), 0);
    chk("rst_psel", psel == 1'b0, 64'(psel), 0);
    chk("rst_penable", penable == 1'b0, 64'(penable), 0);
    chk("rst_pwrite", pwrite == 1'b0, 64'(pwrite), 0);
    chk("rst_paddr", paddr == '0, 64'(paddr), 0);
    chk("rst_pwdata", pwdata == 32'h0, 64'(pwdata), 0);
    chk("rst_pstrb", pstrb == 4'h0, 64'(pstrb), 0);
    chk("rst_pprot", pprot == 3'b000, 64'(pprot), 0);
    chk("rst_crc_valid", crc_valid == 1'b0, 64'(crc_valid), 0);
    chk("rst_crc", crc == 32'h0, 64'(crc), 0);
    chk("rst_err", err == 1'b0, 64'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_s_ready", s_ready == 1'b0, 64'(s_ready), 0);

    // "123456789", zero wait states; DONE is the 5th cycle after the last-byte edge.
    frame = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(0, 32'hCBF4_3926, -1, 32'hCBF4_3926, 1'b0, 4);

    // Same frame, 3 wait states per access: +3 on each of the last two transfers.
    run_frame(3, 32'h0BAD_F00D, -1, 32'h0BAD_F00D, 1'b0, 10);

    // Slave error on the second DATA write: drain, no READ, crc held.
    run_frame(0, 32'h1111_1111, 2, 32'h0BAD_F00D, 1'b1, -1);

    // Reset while the first DATA write waits in ACCESS.
    waits    = 3;
    err_at   = -1;
    xfer_idx = 0;
    frame    = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_apb.push_back('{1'b1, 12'h000, 32'h1, 4'hF});
    for (int i = 0; i < (PACK_MODE ? 4 : 1); i++) send_byte(frame[i], 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (!(psel && penable) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_data_access", psel && penable && pwrite && paddr == 12'h004, {psel, penable, pwrite, paddr}, {3'b111, 12'h004});
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_drops_psel", {psel, penable, s_ready} == 3'b000, {psel, penable, s_ready}, 0);
    rst = 1'b0;
    chk("rst_init_seen", exp_apb.size() == 0, 64'(exp_apb.size()), 0);
    repeat (8) @(negedge clk);

    // Single byte: starts again with INIT, one DATA write strobe 0001.
    frame = {8'hA5};
    run_frame(0, 32'h5A5A_5A5A, -1, 32'h5A5A_5A5A, 1'b0, 4);

    // Three-byte frame, 1 wait state.
    frame = {8'h10, 8'h20, 8'h30};
    run_frame(1, 32'h00C0_FFEE, -1, 32'h00C0_FFEE, 1'b0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
